usb_linemon: RTL and testbench

Synthesizable USB line-state monitor for the device transceiver receive path, running on the 4x bit-rate clock beside the transaction core. Samples raw `drx_plus`/`drx_minus`, synchronizes and glitch-filters them, and decodes speed-dependent J/K/SE0/SE1. Tracks bus events (bus reset, suspend, resume) with run-length counters and a 4-state machine. Replaces ad-hoc pull-up/line checks with parametrised, speed-aware detection.

---
 rtl/usb_linemon.sv | 190 +++++++++++++++++++
 tb/tb_usb_linemon.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_linemon.sv
// usb_linemon: USB line-state monitor for the device receive path.
// Runs on the 4x bit-rate clock. Synchronizes and glitch-filters the raw
// D+/D- levels, decodes J/K/SE0/SE1 for the current device speed, and tracks
// bus reset / suspend / resume with a run-length counter and a small FSM.
// Optional feature: define USB_LINEMON_SE1_CNT_EN to build the saturating
// SE1 event counter on se1_count (otherwise se1_count is tied to zero).
module usb_linemon #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int CNT_W       = 18,
  parameter int RST_TICKS   = 120,
  parameter int SUSP_TICKS  = 144000
) (
  input  logic       clk_4xrate,
  input  logic       rst0_sync,
  input  logic       device_speed,
  input  logic       drx_plus,
  input  logic       drx_minus,
  output logic [1:0] line_state,
  output logic [1:0] bus_state,
  output logic       bus_reset,
  output logic       bus_reset_tick,
  output logic       suspend,
  output logic       resume_tick,
  output logic       se1_tick,
  output logic [7:0] se1_count
);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  localparam logic [CNT_W-1:0] RST_LIM  = CNT_W'(RST_TICKS - 1);
  localparam logic [CNT_W-1:0] SUSP_LIM = CNT_W'(SUSP_TICKS - 1);

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'b00,
    ST_RESET   = 2'b01,
    ST_SUSPEND = 2'b10,
    ST_RESUME  = 2'b11
  } bus_st_t;

  // J is dp=1/dn=0 at full speed and the mirror image at low speed.
  function automatic logic [1:0] decode_line(input logic dp, input logic dn,
                                             input logic fs);
    logic [1:0] st;
    case ({dp, dn})
      2'b00:   st = LS_SE0;
      2'b11:   st = LS_SE1;
      2'b10:   st = fs ? LS_J : LS_K;
      default: st = fs ? LS_K : LS_J;
    endcase
    return st;
  endfunction

  logic [SYNC_STAGES-1:0] dp_sync_p0;
  logic [SYNC_STAGES-1:0] dn_sync_p0;
  logic                   spd_p0;
  logic [1:0]             raw_p1;
  logic                   filt_stable;
  logic                   ls_load;
  logic                   spd_toggle;
  logic [CNT_W-1:0]       run_cnt_p2;
  bus_st_t                st;

  // ---- stage p0: synchronizers (MSB is the oldest, fully synchronized bit)
  // Shift raw line levels through the synchronizer chains.
  always_ff @(posedge clk_4xrate) begin
    if (!rst0_sync) begin
      dp_sync_p0 <= '0;
      dn_sync_p0 <= '0;
    end else begin
      dp_sync_p0 <= {dp_sync_p0[SYNC_STAGES-2:0], drx_plus};
      dn_sync_p0 <= {dn_sync_p0[SYNC_STAGES-2:0], drx_minus};
    end
  end

  // ---- stage p1: decode with the live speed, then the equal-sample filter
  assign raw_p1 = decode_line(dp_sync_p0[SYNC_STAGES-1],
                              dn_sync_p0[SYNC_STAGES-1], device_speed);

  // The current decode counts as the newest of the FILTER_LEN samples, so
  // only FILTER_LEN-1 older samples need storage.
  if (FILTER_LEN > 1) begin : g_filt
    logic [1:0] hist_p1 [FILTER_LEN-1];

    // Keep the previous FILTER_LEN-1 decoded states.
    always_ff @(posedge clk_4xrate) begin
      if (!rst0_sync) begin
        for (int i = 0; i < FILTER_LEN - 1; i++) hist_p1[i] <= LS_SE0;
      end else begin
        hist_p1[0] <= raw_p1;
        for (int i = 1; i < FILTER_LEN - 1; i++) hist_p1[i] <= hist_p1[i-1];
      end
    end

    // The window is stable when every stored sample matches the current one.
    always_comb begin
      filt_stable = 1'b1;
      for (int i = 0; i < FILTER_LEN - 1; i++)
        if (hist_p1[i] != raw_p1) filt_stable = 1'b0;
    end
  end else begin : g_nofilt
    assign filt_stable = 1'b1;
  end

  assign ls_load    = filt_stable && (raw_p1 != line_state);
  assign spd_toggle = (device_speed != spd_p0);

  // ---- stage p2: accepted line state, run-length counter, SE1 pulse
  // Accept a new line state and time how long it has been held.
  always_ff @(posedge clk_4xrate) begin
    if (!rst0_sync) begin
      line_state <= LS_J;
      run_cnt_p2 <= '0;
      spd_p0     <= device_speed;
      se1_tick   <= 1'b0;
    end else begin
      spd_p0   <= device_speed;
      se1_tick <= ls_load && (raw_p1 == LS_SE1);
      if (ls_load) line_state <= raw_p1;
      if (ls_load || spd_toggle) run_cnt_p2 <= '0;
      else if (run_cnt_p2 != '1) run_cnt_p2 <= run_cnt_p2 + 1'b1;
    end
  end

  // ---- stage p3: bus-event FSM with registered levels and pulses
  // Bus state machine; a bus reset always wins over suspend/resume.
  always_ff @(posedge clk_4xrate) begin
    if (!rst0_sync) begin
      st             <= ST_ACTIVE;
      bus_reset      <= 1'b0;
      bus_reset_tick <= 1'b0;
      suspend        <= 1'b0;
      resume_tick    <= 1'b0;
    end else begin
      bus_reset_tick <= 1'b0;
      resume_tick    <= 1'b0;
      case (st)
        ST_ACTIVE: begin
          if (line_state == LS_SE0 && run_cnt_p2 >= RST_LIM) begin
            st             <= ST_RESET;
            bus_reset      <= 1'b1;
            bus_reset_tick <= 1'b1;
          end else if (line_state == LS_J && run_cnt_p2 >= SUSP_LIM) begin
            st      <= ST_SUSPEND;
            suspend <= 1'b1;
          end
        end
        ST_RESET: begin
          if (line_state != LS_SE0) begin
            st        <= ST_ACTIVE;
            bus_reset <= 1'b0;
          end
        end
        ST_SUSPEND: begin
          if (line_state == LS_SE0 && run_cnt_p2 >= RST_LIM) begin
            st             <= ST_RESET;
            bus_reset      <= 1'b1;
            bus_reset_tick <= 1'b1;
            suspend        <= 1'b0;
          end else if (line_state == LS_K) begin
            st          <= ST_RESUME;
            resume_tick <= 1'b1;
          end
        end
        default: begin
          if (line_state == LS_SE0 || line_state == LS_J) begin
            st      <= ST_ACTIVE;
            suspend <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus_state = st;

`ifdef USB_LINEMON_SE1_CNT_EN
  // Saturating count of SE1 events, cleared only by reset.
  always_ff @(posedge clk_4xrate) begin
    if (!rst0_sync) se1_count <= '0;
    else if (se1_tick && se1_count != 8'hFF) se1_count <= se1_count + 8'd1;
  end
`else
  assign se1_count = 8'd0;
`endif

endmodule

// File: tb/tb_usb_linemon.sv
// Testbench for usb_linemon: directed segment table, an SE1 burst, and
// randomized line activity, all compared against a behavioural model.
module tb_usb_linemon;

  localparam int S  = 2;
  localparam int F  = 3;
  localparam int CW = 18;
  localparam int RT = 16;
  localparam int ST = 64;
  localparam int AGE_MAX = (1 << CW) - 1;
`ifdef USB_LINEMON_SE1_CNT_EN
  localparam int EXP_SE1 = 255;
`else
  localparam int EXP_SE1 = 0;
`endif

  localparam int B_ACT = 0, B_RST = 1, B_SUS = 2, B_RES = 3;

  logic       clk = 1'b0;
  logic       rstn, spd, dp, dn;
  logic [1:0] line_state, bus_state;
  logic       bus_reset, bus_reset_tick, suspend, resume_tick, se1_tick;
  logic [7:0] se1_count;

  usb_linemon #(
    .SYNC_STAGES(S), .FILTER_LEN(F), .CNT_W(CW),
    .RST_TICKS(RT), .SUSP_TICKS(ST)
  ) dut (
    .clk_4xrate     (clk),
    .rst0_sync      (rstn),
    .device_speed   (spd),
    .drx_plus       (dp),
    .drx_minus      (dn),
    .line_state     (line_state),
    .bus_state      (bus_state),
    .bus_reset      (bus_reset),
    .bus_reset_tick (bus_reset_tick),
    .suspend        (suspend),
    .resume_tick    (resume_tick),
    .se1_tick       (se1_tick),
    .se1_count      (se1_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int seg_rt, seg_rs, se1_seen;

  // Behavioural model: pin delay line, recent decodes, accepted state, age.
  logic [1:0] m_pipe[$];
  logic [1:0] m_win[$];
  logic [1:0] m_ls = 2'b01;
  int         m_age = 0;
  int         m_bus = B_ACT;
  logic       m_rtick = 1'b0, m_rstick = 1'b0, m_s1tick = 1'b0;
  int         m_s1cnt = 0;
  logic       m_spd = 1'b1;

  // Idle level (J) has D+ high at full speed, D- high at low speed.
  function automatic logic [1:0] decode(input logic p, input logic m, input logic fs);
    if (p == m) return p ? 2'b11 : 2'b00;
    return (p == fs) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_step();
    logic [1:0] raw;
    logic agree, change, rst_hit;
    if (!rstn) begin
      m_pipe = {};
      m_win  = {};
      for (int i = 0; i < S; i++) m_pipe.push_back(2'b00);
      for (int i = 0; i < F - 1; i++) m_win.push_back(2'b00);
      m_ls = 2'b01; m_age = 0; m_bus = B_ACT;
      m_rtick = 1'b0; m_rstick = 1'b0; m_s1tick = 1'b0; m_s1cnt = 0;
      m_spd = spd;
      return;
    end
    raw = decode(m_pipe[0][1], m_pipe[0][0], spd);
    agree = 1'b1;
    foreach (m_win[i]) if (m_win[i] != raw) agree = 1'b0;
    change  = agree && (raw != m_ls);
    rst_hit = (m_ls == 2'b00) && (m_age >= RT - 1);
    m_rtick  = 1'b0;
    m_rstick = 1'b0;
`ifdef USB_LINEMON_SE1_CNT_EN
    if (m_s1tick && m_s1cnt < 255) m_s1cnt++;
`endif
    m_s1tick = change && (raw == 2'b11);
    case (m_bus)
      B_ACT: if (rst_hit) begin m_bus = B_RST; m_rtick = 1'b1; end
             else if (m_ls == 2'b01 && m_age >= ST - 1) m_bus = B_SUS;
      B_RST: if (m_ls != 2'b00) m_bus = B_ACT;
      B_SUS: if (rst_hit) begin m_bus = B_RST; m_rtick = 1'b1; end
             else if (m_ls == 2'b10) begin m_bus = B_RES; m_rstick = 1'b1; end
      default: if (m_ls == 2'b00 || m_ls == 2'b01) m_bus = B_ACT;
    endcase
    if (change || spd != m_spd) m_age = 0;
    else if (m_age < AGE_MAX) m_age++;
    if (change) m_ls = raw;
    m_spd = spd;
    m_pipe.push_back({dp, dn});
    void'(m_pipe.pop_front());
    m_win.push_front(raw);
    void'(m_win.pop_back());
  endtask

  task automatic check_model();
    logic e_brst, e_susp;
    e_brst = (m_bus == B_RST);
    e_susp = (m_bus == B_SUS) || (m_bus == B_RES);
    checks++;
    if (line_state !== m_ls || bus_state !== 2'(m_bus) || bus_reset !== e_brst ||
        bus_reset_tick !== m_rtick || suspend !== e_susp || resume_tick !== m_rstick ||
        se1_tick !== m_s1tick || se1_count !== 8'(m_s1cnt)) begin
      errors++;
      if (errors <= 20)
        $display("FAIL model cyc=%0d actual ls=%b bus=%b brst=%b btick=%b susp=%b rtick=%b s1=%b cnt=%0d required ls=%b bus=%0d brst=%b btick=%b susp=%b rtick=%b s1=%b cnt=%0d",
                 cyc, line_state, bus_state, bus_reset, bus_reset_tick, suspend, resume_tick,
                 se1_tick, se1_count, m_ls, m_bus, e_brst, m_rtick, e_susp, m_rstick,
                 m_s1tick, m_s1cnt);
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check after.
  task automatic tick(input logic t_dp, input logic t_dn, input logic t_spd, input logic t_rstn);
    dp = t_dp; dn = t_dn; spd = t_spd; rstn = t_rstn;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    if (bus_reset_tick) seg_rt++;
    if (resume_tick) seg_rs++;
    if (se1_tick) se1_seen++;
    check_model();
  endtask

  typedef struct {
    logic       spd, dp, dn, rstn;
    int         n;
    logic [1:0] ls, bus;
    logic       susp;
    int         rt, rs;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic s, input logic p, input logic m, input logic r,
                              input int n, input logic [1:0] ls, input logic [1:0] bus,
                              input logic su, input int rt, input int rs);
    vec_t v;
    v.spd = s; v.dp = p; v.dn = m; v.rstn = r; v.n = n;
    v.ls = ls; v.bus = bus; v.susp = su; v.rt = rt; v.rs = rs;
    tbl.push_back(v);
  endfunction

  logic       rspd;
  logic [1:0] rp;
  logic       rr;
  int         rlen;

  initial begin
    //  spd dp dn rstn  n   ls     bus   susp rt rs
    add(1, 1, 0, 0,   3, 2'b01, 2'b00, 0, 0, 0);  // reset with idle J
    add(1, 1, 0, 1,  10, 2'b01, 2'b00, 0, 0, 0);  // release, settle on J
    add(1, 0, 0, 1,  22, 2'b00, 2'b01, 0, 1, 0);  // SE0 long enough for bus reset
    add(1, 1, 0, 1,   6, 2'b01, 2'b00, 0, 0, 0);  // J returns, back to ACTIVE
    add(1, 0, 1, 1,   2, 2'b01, 2'b00, 0, 0, 0);  // 2-cycle K glitch
    add(1, 1, 0, 1,   6, 2'b01, 2'b00, 0, 0, 0);  // glitch never reached line_state
    add(1, 0, 1, 1,   5, 2'b10, 2'b00, 0, 0, 0);  // K accepted after S+F cycles
    add(1, 1, 0, 1,   6, 2'b01, 2'b00, 0, 0, 0);
    add(1, 1, 0, 1,  70, 2'b01, 2'b10, 1, 0, 0);  // idle J -> suspend
    add(1, 0, 1, 1,  10, 2'b10, 2'b11, 1, 0, 1);  // K -> resume pulse
    add(1, 0, 0, 1,   3, 2'b10, 2'b11, 1, 0, 0);  // SE0 still in the pipeline
    add(1, 1, 0, 1,   8, 2'b01, 2'b00, 0, 0, 0);  // SE0 then J ends resume
    add(0, 0, 1, 1,   8, 2'b01, 2'b00, 0, 0, 0);  // low speed idle J
    add(1, 0, 1, 1,   5, 2'b10, 2'b00, 0, 0, 0);  // same pins at full speed are K
    add(1, 1, 0, 1,   6, 2'b01, 2'b00, 0, 0, 0);
    add(1, 0, 0, 1,  15, 2'b00, 2'b00, 0, 0, 0);  // SE0, counter at 10
    add(1, 0, 0, 0,   2, 2'b01, 2'b00, 0, 0, 0);  // reset aborts the SE0 event
    add(1, 1, 0, 1,  12, 2'b01, 2'b00, 0, 0, 0);  // no bus reset afterwards

    rstn = 1'b0; spd = 1'b1; dp = 1'b1; dn = 1'b0;
    @(negedge clk);

    foreach (tbl[k]) begin
      seg_rt = 0;
      seg_rs = 0;
      for (int c = 0; c < tbl[k].n; c++) tick(tbl[k].dp, tbl[k].dn, tbl[k].spd, tbl[k].rstn);
      checks++;
      if (line_state !== tbl[k].ls || bus_state !== tbl[k].bus || suspend !== tbl[k].susp ||
          bus_reset !== (tbl[k].bus == 2'b01)) begin
        errors++;
        $display("FAIL vec%0d_state actual ls=%b bus=%b susp=%b brst=%b required ls=%b bus=%b susp=%b",
                 k, line_state, bus_state, suspend, bus_reset, tbl[k].ls, tbl[k].bus, tbl[k].susp);
      end
      checks++;
      if (seg_rt != tbl[k].rt || seg_rs != tbl[k].rs) begin
        errors++;
        $display("FAIL vec%0d_pulses actual reset_ticks=%0d resume_ticks=%0d required %0d %0d",
                 k, seg_rt, seg_rs, tbl[k].rt, tbl[k].rs);
      end
    end

    // 300 separated SE1 events at full speed.
    se1_seen = 0;
    for (int e = 0; e < 300; e++) begin
      repeat (4) tick(1'b1, 1'b1, 1'b1, 1'b1);
      repeat (6) tick(1'b1, 1'b0, 1'b1, 1'b1);
    end
    checks++;
    if (se1_seen != 300) begin
      errors++;
      $display("FAIL se1_pulses actual=%0d required=300", se1_seen);
    end
    checks++;
    if (se1_count !== 8'(EXP_SE1)) begin
      errors++;
      $display("FAIL se1_count actual=%0d required=%0d", se1_count, EXP_SE1);
    end

    // Randomized line activity with occasional speed toggles and resets.
    rspd = 1'b1;
    for (int s = 0; s < 400; s++) begin
      rp = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) rspd = ~rspd;
      rr = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 4) == 0) rlen = $urandom_range(10, 90);
      else rlen = $urandom_range(1, 6);
      repeat (rlen) tick(rp[1], rp[0], rspd, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
